// File: rtl/alu_dispatch.sv
// Operand dispatch ahead of pipelined_alu. Requests are queued in a FIFO and
// issued against downstream result credits. A shadow pipe tags the valid ALU results.
module alu_dispatch #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned CREDITS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic [3:0]                 in_op,
  input  logic [TAG_W-1:0]           in_tag,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [3:0]                 alu_op,
  output logic                       out_valid,
  output logic [TAG_W-1:0]           out_tag,
  input  logic                       credit_return,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       credit_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CRD_W = $clog2(CREDITS + 1);
  localparam int unsigned NSHD  = ALU_LAT + 1;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
  } shd_t;

  req_t             mem_q [DEPTH];
  req_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CRD_W-1:0] crd_q, crd_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  shd_t             shd_q [NSHD];
  shd_t             shd_d [NSHD];
  logic             err_q, err_d;
  logic             push;
  logic             pop;
  req_t             head;

  assign in_ready = (cnt_q != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (cnt_q != '0) && (crd_q != '0);
  assign head     = mem_q[rd_ptr_q];

  // Next-state: FIFO, issue registers, shadow pipe and credit accounting
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    crd_d    = crd_q;
    err_d    = err_q;
    alu_a_d  = '0;
    alu_b_d  = '0;
    alu_op_d = 4'b0000;
    shd_d    = shd_q;
    shd_d[0] = '0;

    if (push) begin
      mem_d[wr_ptr_q] = '{op: in_op, a: in_a, b: in_b, tag: in_tag};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      alu_a_d  = head.a;
      alu_b_d  = head.b;
      alu_op_d = head.op;
      shd_d[0] = '{vld: 1'b1, tag: head.tag};
    end

    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

    for (int i = 1; i < int'(NSHD); i++) begin
      shd_d[i] = shd_q[i-1];
    end

    // A return with no room to hold it is dropped and flagged
    if (pop && !credit_return) begin
      crd_d = crd_q - CRD_W'(1);
    end else if (credit_return && !pop) begin
      if (crd_q == CRD_W'(CREDITS)) begin
        err_d = 1'b1;
      end else begin
        crd_d = crd_q + CRD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      for (int i = 0; i < int'(NSHD); i++) begin
        shd_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      crd_q    <= CRD_W'(CREDITS);
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      shd_q    <= shd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      crd_q    <= crd_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      err_q    <= err_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign out_valid  = shd_q[ALU_LAT].vld;
  assign out_tag    = shd_q[ALU_LAT].tag;
  assign fifo_count = cnt_q;
  assign credit_err = err_q;

endmodule
